// File: rtl/bcd_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_WIDTH  = 32;
  localparam int BCD_DIGITS = 10;

  typedef logic [3:0] bcd_nibble_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_nibble_t din,
  output bcd_nibble_t dout
);

  // Inputs never exceed 9, so the +3 result stays within 4 bits.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: WIDTH-bit binary to DIGITS packed BCD
// digits, one correct/shift step per clock. The published result (bcd/neg)
// only changes in the cycle after DONE, so the display never sees partials.
// Optional feature macro: BCD_SIGNED_EN (two's-complement input, neg output).
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  bcd_state_t          state_q, state_d;
  logic [SW-1:0]       scratch_q;
  logic [WIDTH-1:0]    shreg_q;
  logic [CW-1:0]       cnt_q;
  logic                sign_q;
  logic                load, step, publish;

  logic [WIDTH-1:0]    mag;
  logic                sign_in;
  logic [DIGITS-1:0][3:0] corr;
  logic [SW-1:0]       corr_flat;

  // Magnitude and sign of the incoming operand.
`ifdef BCD_SIGNED_EN
  always_comb begin
    sign_in = bin[WIDTH-1];
    mag     = sign_in ? (~bin + 1'b1) : bin;
  end
`else
  always_comb begin
    sign_in = 1'b0;
    mag     = bin;
  end
`endif

  // Per-digit +3 correction applied to the scratch before each shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (scratch_q[4*i +: 4]),
      .dout (corr[i])
    );
  end
  assign corr_flat = corr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    publish = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers: capture on accept, correct-and-shift while converting.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
    end else if (load) begin
      scratch_q <= '0;
      shreg_q   <= mag;
      cnt_q     <= CW'(WIDTH);
      sign_q    <= sign_in;
    end else if (step) begin
      scratch_q <= {corr_flat[SW-2:0], shreg_q[WIDTH-1]};
      shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
      cnt_q     <= cnt_q - 1'b1;
    end
  end

  // Published result and completion pulse; held steady between conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd  <= '0;
      neg  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= publish;
      if (publish) begin
        bcd <= scratch_q;
        neg <= sign_q;
      end
    end
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq. Expected values are hand-computed
// decimal renderings of each operand. Adapts to BCD_SIGNED_EN.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic        neg;

  int vecs = 0;
  int errs = 0;

  bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .neg   (neg)
  );

  always #5 clk = ~clk;

  // Runs one conversion; samples 1 time unit after each edge, k=0 is edge T0.
  task automatic run_conv(input logic [31:0] v, output logic [39:0] res,
                          output logic res_neg, output int done_k,
                          output int busy_n, output int done_n,
                          output bit held);
    logic [39:0] prev;
    prev   = bcd;
    res    = 'x;
    res_neg = 1'bx;
    done_k = -1;
    busy_n = 0;
    done_n = 0;
    held   = 1'b1;
    start  = 1'b1;
    bin    = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bin    = 32'hDEAD_BEEF;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k  = k;
          res     = bcd;
          res_neg = neg;
        end
      end
      if (done_k < 0 && bcd !== prev) held = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
    vecs++; if (bcd !== 40'h0) begin errs++; $display("FAIL reset_bcd got %h want 0", bcd); end
    vecs++; if (neg !== 1'b0) begin errs++; $display("FAIL reset_neg got %b want 0", neg); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    logic [39:0] r; logic n; int dk, bn, dn; bit h;
    run_conv(32'd0, r, n, dk, bn, dn, h);
    vecs++; if (dk !== 33) begin errs++; $display("FAIL zero_done_time got %0d want 33", dk); end
    vecs++; if (bn !== 32) begin errs++; $display("FAIL zero_busy_cycles got %0d want 32", bn); end
    vecs++; if (dn !== 1) begin errs++; $display("FAIL zero_done_width got %0d want 1", dn); end
    vecs++; if (r !== 40'h00_0000_0000) begin errs++; $display("FAIL zero_bcd got %h want 0", r); end
    vecs++; if (n !== 1'b0) begin errs++; $display("FAIL zero_neg got %b want 0", n); end
  endtask

  task automatic test_values;
    logic [39:0] r; logic n; int dk, bn, dn; bit h;
    run_conv(32'd1234, r, n, dk, bn, dn, h);
    vecs++; if (r !== 40'h00_0000_1234) begin errs++; $display("FAIL bcd_1234 got %h want 0000001234", r); end
    vecs++; if (dk !== 33) begin errs++; $display("FAIL time_1234 got %0d want 33", dk); end
    run_conv(32'd9999, r, n, dk, bn, dn, h);
    vecs++; if (r !== 40'h00_0000_9999) begin errs++; $display("FAIL bcd_9999 got %h want 0000009999", r); end
    vecs++; if (h !== 1'b1) begin errs++; $display("FAIL hold_prev got %b want 1 (bcd changed before done)", h); end
    vecs++; if (bcd !== 40'h00_0000_9999) begin errs++; $display("FAIL hold_after got %h want 0000009999", bcd); end
  endtask

  task automatic test_extremes;
    logic [39:0] r; logic n; int dk, bn, dn; bit h;
    run_conv(32'hFFFF_FFFF, r, n, dk, bn, dn, h);
`ifdef BCD_SIGNED_EN
    vecs++; if (r !== 40'h00_0000_0001) begin errs++; $display("FAIL bcd_allones got %h want 0000000001", r); end
    vecs++; if (n !== 1'b1) begin errs++; $display("FAIL neg_allones got %b want 1", n); end
`else
    vecs++; if (r !== 40'h42_9496_7295) begin errs++; $display("FAIL bcd_allones got %h want 4294967295", r); end
    vecs++; if (n !== 1'b0) begin errs++; $display("FAIL neg_allones got %b want 0", n); end
`endif
    run_conv(32'h8000_0000, r, n, dk, bn, dn, h);
    vecs++; if (r !== 40'h21_4748_3648) begin errs++; $display("FAIL bcd_minint got %h want 2147483648", r); end
`ifdef BCD_SIGNED_EN
    vecs++; if (n !== 1'b1) begin errs++; $display("FAIL neg_minint got %b want 1", n); end
`else
    vecs++; if (n !== 1'b0) begin errs++; $display("FAIL neg_minint got %b want 0", n); end
`endif
    run_conv(32'd7, r, n, dk, bn, dn, h);
    vecs++; if (r !== 40'h00_0000_0007 || n !== 1'b0) begin errs++; $display("FAIL bcd_7 got %h/%b want 0000000007/0", r, n); end
  endtask

  // start held high with a changing operand; only the accept edges matter.
  task automatic test_back_to_back;
    int done_k1 = -1, acc2_k = -1, done_k2 = -1;
    logic [39:0] r1 = 'x, r2 = 'x;
    start = 1'b1;
    bin   = 32'd12345678;
    @(posedge clk); #1;                // edge T0, k=0
    for (int k = 0; k < 72; k++) begin
      if (done && done_k1 < 0) begin done_k1 = k; r1 = bcd; end
      else if (done && done_k1 >= 0 && done_k2 < 0) begin done_k2 = k; r2 = bcd; end
      if (k >= 33 && busy && acc2_k < 0) acc2_k = k;
      bin = (k == 33) ? 32'd87654321 : 32'd1000 + 32'(k);
      if (k == 34) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    vecs++; if (r1 !== 40'h00_1234_5678) begin errs++; $display("FAIL b2b_first got %h want 0012345678", r1); end
    vecs++; if (done_k1 !== 33) begin errs++; $display("FAIL b2b_done1 got %0d want 33", done_k1); end
    vecs++; if (acc2_k !== 34) begin errs++; $display("FAIL b2b_next_accept got %0d want 34", acc2_k); end
    vecs++; if (r2 !== 40'h00_8765_4321) begin errs++; $display("FAIL b2b_second got %h want 0087654321", r2); end
    vecs++; if (done_k2 !== 67) begin errs++; $display("FAIL b2b_done2 got %0d want 67", done_k2); end
  endtask

  task automatic test_abort;
    logic [39:0] r; logic n; int dk, bn, dn; bit h;
    int seen = 0;
    start = 1'b1; bin = 32'd999;
    @(posedge clk); #1;                // edge T0
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;                // edge T0+10
    rst = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", busy); end
    vecs++; if (bcd !== 40'h0) begin errs++; $display("FAIL abort_bcd got %h want 0", bcd); end
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    run_conv(32'd42, r, n, dk, bn, dn, h);
    vecs++; if (r !== 40'h00_0000_0042) begin errs++; $display("FAIL after_abort got %h want 0000000042", r); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    test_reset();
    test_zero();
    test_values();
    test_extremes();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
